// File: rtl/seq_divider4_pkg.sv
// ----------------------------------------------------------------------------
// seq_divider4_pkg
// Shared constants for the sequential restoring divider: operand width,
// controller state encodings and the iteration counter load value.
// No ports (package).
// ----------------------------------------------------------------------------
package seq_divider4_pkg;

   localparam int DIV_WIDTH = 4;

   // Iteration counter: loaded with DIV_WIDTH-1 and counts down to 0,
   // so one quotient bit is produced per CALC cycle.
   localparam int             CNT_W     = 2;
   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DIV_WIDTH - 1);

   // Controller state encodings.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider4_if.sv
// ----------------------------------------------------------------------------
// seq_divider4_if
// Request/result bundle of the divider.
//   start        requester -> divider  request a division (taken only when idle)
//   dividend     requester -> divider  unsigned dividend, sampled on accept
//   divisor      requester -> divider  unsigned divisor, sampled on accept
//   busy         divider -> requester  operation in progress (CALC or DONE)
//   done         divider -> requester  one-cycle pulse, results valid
//   quotient     divider -> requester  held until a later result replaces it
//   remainder    divider -> requester  held like quotient
//   div_by_zero  divider -> requester  captured divisor was zero, held
// Handshake: a request is accepted on a rising edge where start=1 and busy=0;
// start while busy=1 is dropped, not queued. Each accepted request produces
// exactly one done pulse a fixed four edges later unless reset intervenes.
// ----------------------------------------------------------------------------
interface seq_divider4_if
   import seq_divider4_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider4_addsub4_co.sv
// ----------------------------------------------------------------------------
// addsub4_co
// Ripple-carry adder/subtractor built from 1-bit full adders.
//   a, b       operands
//   sub        1: sum = a + ~b + 1 (a - b), 0: sum = a + b
//   sum        result modulo 2^WIDTH
//   carry_out  carry from the MSB; in subtract mode 1 means a >= b
// ----------------------------------------------------------------------------
module addsub4_co #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] bx;

   // sub doubles as the carry-in, giving two's complement negation of b.
   assign c[0] = sub;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign bx[i]    = b[i] ^ sub;
      assign sum[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
   end

   assign carry_out = c[WIDTH];

endmodule

// File: rtl/seq_divider4.sv
// ----------------------------------------------------------------------------
// seq_divider4
// Sequential restoring divider, one quotient bit per clock, MSB first.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, aborts any operation
//   bus        seq_divider4_if.slave: start/dividend/divisor in,
//              busy/done/quotient/remainder/div_by_zero out
//   state_dbg  current controller state (ST_IDLE/ST_CALC/ST_DONE)
// Accept edge N loads the operands, CALC runs on edges N+1..N+4, the results
// register on N+4 and done is high for the cycle that follows.
// ----------------------------------------------------------------------------
module seq_divider4
   import seq_divider4_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   seq_divider4_if.slave   bus,
   output logic [1:0]      state_dbg
);

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] r;          // partial remainder
   logic [WIDTH-1:0] q;          // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] divisor_q;  // divisor latched at accept

   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;

   logic [WIDTH-1:0] s;
   logic             t;
   logic [WIDTH-1:0] d;
   logic             carry_out;
   logic             take;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   // Shift the next dividend bit into the partial remainder. The bit pushed
   // out of r (t) is the hidden fifth bit of the true shifted value.
   assign s = {r[WIDTH-2:0], q[WIDTH-1]};
   assign t = r[WIDTH-1];

   addsub4_co #(.WIDTH(WIDTH)) u_sub (
      .a         (s),
      .b         (divisor_q),
      .sub       (1'b1),
      .sum       (d),
      .carry_out (carry_out)
   );

   // When t=1 the 5-bit value exceeds any 4-bit divisor, so the subtraction
   // must be taken and d is still correct modulo 2^WIDTH. A zero divisor
   // always produces carry_out=1, giving an all-ones quotient and the
   // dividend as remainder without any special casing.
   assign take   = t | carry_out;
   assign r_next = take ? d : s;
   assign q_next = {q[WIDTH-2:0], take};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         r           <= '0;
         q           <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  divisor_q <= bus.divisor;
                  r         <= '0;
                  q         <= bus.dividend;
                  count     <= ITER_LAST;
                  state     <= ST_CALC;
               end
            end
            ST_CALC: begin
               r     <= r_next;
               q     <= q_next;
               count <= count - CNT_W'(1);
               if (count == '0) begin
                  quotient_q  <= q_next;
                  remainder_q <= r_next;
                  dbz_q       <= (divisor_q == '0);
                  state       <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // busy and done are plain decodes of the state register.
   assign bus.busy        = (state != ST_IDLE);
   assign bus.done        = (state == ST_DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_seq_divider4.sv
// ----------------------------------------------------------------------------
// tb_seq_divider4
// Self-checking bench for seq_divider4: reset state, a table of known
// quotients/remainders, an ignored mid-operation start, a mid-operation
// reset, random operations against an arithmetic reference, and an
// exhaustive back-to-back sweep with done-spacing checks.
// ----------------------------------------------------------------------------
module tb_seq_divider4;
   import seq_divider4_pkg::*;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic       z;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [1:0] state_dbg;

   seq_divider4_if bus ();

   seq_divider4 dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock/reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];   // {div_by_zero, quotient, remainder}
   int         checks = 0;
   int         errors = 0;
   int         done_count = 0;
   int         cyc = 0;
   int         last_done = -1;
   bit         sweep_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division; a zero divisor yields all-ones
   // quotient and the dividend as remainder.
   function automatic logic [8:0] model(input int a, input int b);
      if (b == 0) return {1'b1, 4'hF, 4'(a)};
      return {1'b0, 4'(a / b), 4'(a % b)};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         logic [8:0] e;
         done_count++;
         check("done_has_expectation", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("quotient", int'(bus.quotient), int'(e[7:4]));
            check("remainder", int'(bus.remainder), int'(e[3:0]));
            check("div_by_zero", int'(bus.div_by_zero), int'(e[8]));
         end
         if (sweep_on) begin
            if (last_done >= 0) check("done_spacing", cyc - last_done, 6);
            last_done = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic [8:0] e);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      // Scramble the operand inputs: the operation in flight must not see it.
      bus.dividend = 4'($urandom);
      bus.divisor  = 4'($urandom);
      check("busy_after_accept", int'(bus.busy), 1);
   endtask

   // Counts negedges from the call point until done; -1 means it never came.
   task automatic wait_done(input int exp_lat);
      int lat;
      lat = -1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      check("done_latency", lat, exp_lat);
   endtask

   task automatic post_done_check();
      @(negedge clk);
      check("done_one_cycle", int'(bus.done), 0);
      check("busy_fall", int'(bus.busy), 0);
   endtask

   // ---------------- test sequence ----------------
   vec_t tbl[9];

   initial begin
      int         n_done;
      logic [3:0] a;
      logic [3:0] b;

      tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
      tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
      tbl[2] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7, z: 1'b0};
      tbl[3] = '{a: 4'd14, b: 4'd7,  q: 4'd2,  r: 4'd0, z: 1'b0};
      tbl[4] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};
      tbl[5] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, z: 1'b1};
      tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
      tbl[7] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
      tbl[8] = '{a: 4'd11, b: 4'd2,  q: 4'd5,  r: 4'd1, z: 1'b0};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_quotient", int'(bus.quotient), 0);
      check("rst_remainder", int'(bus.remainder), 0);
      check("rst_dbz", int'(bus.div_by_zero), 0);
      check("rst_state", int'(state_dbg), int'(ST_IDLE));
      rst = 1'b0;

      // Known vectors.
      for (int i = 0; i < 9; i++) begin
         start_op(tbl[i].a, tbl[i].b, {tbl[i].z, tbl[i].q, tbl[i].r});
         wait_done(4);
         post_done_check();
      end

      // start during CALC with other operands is dropped.
      n_done = done_count;
      start_op(4'd13, 4'd3, {1'b0, 4'd4, 4'd1});
      @(negedge clk);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 4'd6;
      bus.divisor  = 4'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(2);
      post_done_check();
      repeat (10) @(negedge clk);
      check("single_done_ignored_start", done_count - n_done, 1);

      // Reset between N+2 and N+3 aborts the operation.
      n_done = done_count;
      start_op(4'd10, 4'd4, {1'b0, 4'd2, 4'd2});
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      check("abort_quotient", int'(bus.quotient), 0);
      check("abort_remainder", int'(bus.remainder), 0);
      check("abort_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_no_done", done_count - n_done, 0);
      start_op(4'd12, 4'd5, {1'b0, 4'd2, 4'd2});
      wait_done(4);
      post_done_check();

      // Random operations with random idle gaps.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         start_op(a, b, model(int'(a), int'(b)));
         wait_done(4);
         post_done_check();
      end

      // Exhaustive sweep, start held high: accepts land every 6 edges.
      n_done    = done_count;
      sweep_on  = 1'b1;
      last_done = -1;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 4'd0;
      bus.divisor  = 4'd0;
      exp_q.push_back(model(0, 0));
      for (int idx = 0; idx < 256; idx++) begin
         @(posedge clk);
         #1;
         if (idx < 255) begin
            bus.dividend = 4'((idx + 1) / 16);
            bus.divisor  = 4'((idx + 1) % 16);
            exp_q.push_back(model((idx + 1) / 16, (idx + 1) % 16));
            repeat (5) @(posedge clk);
         end else begin
            bus.start = 1'b0;
         end
      end
      wait_done(4);
      post_done_check();
      sweep_on = 1'b0;
      check("sweep_done_count", done_count - n_done, 256);

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider4.md
SEQ_DIVIDER4 -- requirements
Module: seq_divider4

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width; only 4 is required and verified.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  4  unsigned dividend; captured on the accepted start edge.
REQ-006 divisor  input  4  unsigned divisor; captured on the accepted start edge.
REQ-007 busy  output  1  high while a division is in progress (states CALC and DONE).
REQ-008 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 quotient  output  4  unsigned quotient; held after done until the next accepted start.
REQ-010 remainder  output  4  unsigned remainder; held like quotient.
REQ-011 div_by_zero  output  1  set with done when the captured divisor is 0; held like quotient.

Function
REQ-012 Algorithm: restoring division, one quotient bit per CALC cycle, MSB first, using one 4-bit add/sub instance in subtract mode (a + ~b + 1).
REQ-013 FSM states: IDLE, CALC, DONE. IDLE->CALC on start=1; CALC->DONE after the 4th iteration; DONE->IDLE unconditionally after one cycle.
REQ-014 Accept edge N (IDLE, start=1): latch divisor; clear partial remainder R; load shift register Q with dividend; set iteration count to 3; drive busy=1 from edge N.
REQ-015 Each CALC edge: form S = {R[2:0], Q[3]} with shifted-out bit t = R[3]; compute D = S - divisor; if (t | carry_out) then R <= D and shift 1 into Q LSB, else R <= S and shift 0 into Q LSB; decrement count.
REQ-016 Carry_out=1 means S >= divisor (no borrow); t=1 implies the true 5-bit value exceeds divisor, so D is correct modulo 16.
REQ-017 Latency is fixed: CALC on edges N+1..N+4; DONE state after edge N+4; done=1 in cycle N+4..N+5; quotient/remainder/div_by_zero are updated on edge N+4.
REQ-018 Divisor 0: no special path; the algorithm naturally yields quotient=4'hF and remainder=dividend; div_by_zero=1; latency unchanged.
REQ-019 start asserted in CALC or DONE is ignored (no queueing); start held high through DONE is accepted on the first IDLE edge.
REQ-020 Inputs dividend/divisor may change after the accept edge without affecting the operation in progress.
REQ-021 done is high for exactly one cycle per accepted start; busy falls on the edge leaving DONE.

Reset
REQ-022 rst=1 asynchronously forces IDLE; busy, done, quotient, remainder, div_by_zero, R, Q, count all become 0.
REQ-023 Reset mid-operation aborts it; no done is produced for the aborted request; the next start after rst=0 behaves normally.

Structure
REQ-024 Shared package/header: state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2), WIDTH, and the iteration count constant (WIDTH-1).
REQ-025 One sub-module: addsub4_co, a 4-bit ripple add/sub built from 1-bit full adders with sub input and exposed carry-out; seq_divider4 instantiates it once with sub tied to 1.
REQ-026 Controller (FSM, counter) and datapath registers (R, Q, divisor latch) reside in seq_divider4; no other arithmetic operators are used for the subtraction.

Verification
REQ-027 dividend=13, divisor=3, start at edge N -> done at N+4 cycle, quotient=4, remainder=1, div_by_zero=0.
REQ-028 15/1 -> quotient=15, remainder=0; 7/9 -> quotient=0, remainder=7; 14/7 -> quotient=2, remainder=0.
REQ-029 9/0 -> quotient=15, remainder=9, div_by_zero=1, same latency as REQ-017.
REQ-030 start pulsed at N+2 with new operands during CALC -> ignored; results are those of the original operands; exactly one done.
REQ-031 rst asserted between edges N+2 and N+3 -> all outputs 0 immediately, no done; then 12/5 -> quotient=2, remainder=2.
REQ-032 Exhaustive sweep of all 256 operand pairs with back-to-back starts -> every result matches integer / and %, done spacing exactly 6 cycles.
